reg8_piso_tx: RTL
=================

# reg8_piso_tx

Parallel-in/serial-out transmitter for 8-bit register data. It accepts one byte from an upstream 8-bit register through a valid/ready handshake. It then shifts the byte out on a single serial line, holding each bit for a programmable number of clock cycles, and emits a frame strobe and a completion pulse. This is the outbound (reading/transmit) end of the byte-register datapath: register contents leave the datapath through this block.

## Interface
- `DIV`, default 4: clock cycles per serial bit; legal range 1..256.
- `MSB_FIRST`, default 1: 1 = bit 7 first, 0 = bit 0 first.

- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream byte on `in` is valid.
- `in` input 8: byte to transmit.
- `in_ready` output 1: block can accept a byte this cycle.
- `sout` output 1: serial data; idles high.
- `sframe` output 1: high while a byte is being shifted.
- `done` output 1: one-cycle pulse after the last bit period.

## Operation
- States: IDLE, SHIFT.
- IDLE
  - `in_ready`=1, `sframe`=0, `sout`=1.
  - On `in_valid`&`in_ready`, latch `in` into the shift register, clear the bit counter (0..7) and the divide counter (0..DIV-1), and go to SHIFT.
- SHIFT
  - `in_ready`=0, `sframe`=1.
  - `sout` is driven from the current head of the shift register: bit 7 when MSB_FIRST=1, bit 0 otherwise.
  - The divide counter increments every cycle. When it reaches DIV-1, it wraps to 0, the shift register shifts by one toward the head, and the bit counter increments.
  - When the bit counter is 7 and the divide counter is DIV-1, go to IDLE and assert `done` for the following cycle.
- `done` is registered. It is high exactly in the first IDLE cycle after SHIFT and otherwise low.
- `in` and `in_valid` are ignored while in SHIFT. There is no buffering; the upstream side holds its data until `in_ready`.
- Back-to-back transfers: a byte may be accepted in the same cycle that `done`=1. `sout` then returns high for exactly that one cycle between frames.
- Divide counter width is max(1, clog2(DIV)). For DIV=1 the counter is constant 0 and every cycle is a bit boundary.
- Reset (any state, including mid-SHIFT):
  - Next state is IDLE; the partial byte is discarded.
  - Outputs after reset: `sout`=1, `sframe`=0, `done`=0, `in_ready`=1.
  - Shift register and counters are cleared to 0.
- `reset` has priority over a simultaneous handshake; the byte is not accepted.

## Timing
- Let cycle k be the cycle in which `in_valid`&`in_ready`=1.
- Bit i (i=0..7, in transmission order) is on `sout` during cycles k+1+i·DIV through k+(i+1)·DIV.
- `sframe`=1 and `in_ready`=0 during cycles k+1 through k+8·DIV.
- `done`=1 in cycle k+8·DIV+1.
- Minimum accept-to-accept period: 8·DIV+1 cycles.
- All outputs are registered or decoded only from state; there is no combinational path from `in`/`in_valid` to any output.

## Structure
- Shared package `reg8_pkg`:
  - state enum `tx_state_t` {IDLE, SHIFT};
  - localparam `BYTE_W`=8;
  - function `cw(n)` returning max(1, clog2(n)).
- One sub-module is natural: `tick_div`, a modulo-DIV counter with a synchronous clear and a `wrap` output. It is reusable by later serial blocks.
- The shift register, bit counter and FSM stay in `reg8_piso_tx`.

## Test plan
- Reset then idle, DIV=4: hold `reset` 2 cycles, then release with `in_valid`=0 for 10 cycles -> `sout`=1, `sframe`=0, `done`=0, `in_ready`=1 every cycle.
- Single byte, DIV=4, MSB_FIRST=1, `in`=8'hA5 accepted in cycle k:
  - `sout` = 1,0,1,0,0,1,0,1, each held 4 cycles, over k+1..k+32;
  - `sframe`=1 over k+1..k+32;
  - `done`=1 only at k+33.
- LSB order and DIV=1, `in`=8'h01 -> `sout` = 1,0,0,0,0,0,0,0 over k+1..k+8; `done` at k+9.
- Back-to-back, DIV=2: `in_valid` held high with 8'hFF then 8'h00 -> second accept coincides with `done` at k+17; `sout`=1 at k+17; zeros follow over k+18..k+33.
- Busy ignore: `in` changes to 8'h3C during SHIFT of 8'hC3 -> transmitted bits match 8'hC3; `in_ready` stays 0 until `done`.
- Mid-frame reset: assert `reset` at cycle k+10 of a DIV=4 frame -> at k+11, `sout`=1, `sframe`=0, `in_ready`=1; no `done` pulse follows.

Source files
------------

// File: rtl/reg8_pkg.sv
// Shared types, widths and helpers for the byte-register serial datapath blocks.
package reg8_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg8_piso_tx_if.sv
// Byte valid/ready handshake between an upstream register and a transmitter.
interface reg8_piso_tx_if;
    import reg8_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in;
    logic              in_ready;

    modport master (output in_valid, output in, input in_ready);
    modport slave  (input in_valid, input in, output in_ready);

endinterface

// File: rtl/reg8_piso_tx_tick_div.sv
// Modulo-DIV cycle counter with synchronous clear; wrap marks the last cycle of a period.
module tick_div
    import reg8_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic wrap
);

    localparam int            W    = cw(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] count;

    assign wrap = en && (count == LAST);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/reg8_piso_tx.sv
// Parallel-in/serial-out byte transmitter: accepts a byte, shifts it out with DIV cycles per bit.
module reg8_piso_tx
    import reg8_pkg::*;
#(
    parameter int DIV       = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    reg8_piso_tx_if.slave   bus,
    output logic            sout,
    output logic            sframe,
    output logic            done
);

    tx_state_t         state_q, state_d;
    logic [BYTE_W-1:0] shreg;
    logic [2:0]        bit_cnt;
    logic              accept;
    logic              wrap;
    logic              last_bit;

    tick_div #(.DIV(DIV)) u_div (
        .clock (clock),
        .reset (reset),
        .clear (accept),
        .en    (sframe),
        .wrap  (wrap)
    );

    assign last_bit = wrap && (bit_cnt == 3'(BYTE_W - 1));

    // NOTE: defaults are assigned first so no path through this block infers a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset clears the shift register too, so a discarded partial byte never lingers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= last_bit;
            if (accept) begin
                shreg   <= bus.in;
                bit_cnt <= '0;
            end else if (wrap) begin
                shreg   <= MSB_FIRST ? {shreg[BYTE_W-2:0], 1'b0} : {1'b0, shreg[BYTE_W-1:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Outputs decode registered state only; the line idles high between frames.
    assign bus.in_ready = (state_q == IDLE);
    assign sframe       = (state_q == SHIFT);
    assign sout         = sframe ? (MSB_FIRST ? shreg[BYTE_W-1] : shreg[0]) : 1'b1;

endmodule
